// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step-rate generator feeding the half-step phase sequencer.
// Takes a move over valid/ready and emits spaced one-cycle step pulses.
module stepper_move_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 20,
  parameter int START_DIV = 500000,
  parameter int MIN_DIV   = 50000,
  parameter int ACCEL_DEC = 5000
) (
  input  logic             CLK50MHZ,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic             step_pulse,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

  localparam logic [DIV_W-1:0] START_D = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W:0]   START_X = {1'b0, START_D};
  localparam logic [DIV_W:0]   MIN_X   = {1'b0, MIN_D};
  localparam logic [DIV_W:0]   DEC_X   = (DIV_W+1)'(ACCEL_DEC);

  state_t           r_state;
  logic [DIV_W-1:0] r_timer;
  logic [DIV_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_ramp;
  logic [CNT_W-1:0] r_steps_left;
  logic             r_dir;
  logic             r_pulse;
  logic             r_done;
  logic             r_busy;
  logic             r_ready;

  state_t           w_state_next;
  logic [DIV_W-1:0] w_timer_next;
  logic [DIV_W-1:0] w_div_next;
  logic [CNT_W-1:0] w_ramp_next;
  logic [CNT_W-1:0] w_steps_next;
  logic             w_dir_next;
  logic             w_pulse_next;
  logic             w_done_next;
  logic             w_ready_next;
  logic             w_busy_next;
  logic [CNT_W:0]   w_limit;

  logic             w_handshake;
  logic             w_fire;
  logic [CNT_W-1:0] w_n;
  logic [DIV_W:0]   w_div_up;
  logic [DIV_W:0]   w_div_dn;
  logic [DIV_W-1:0] w_div_up_sat;
  logic [DIV_W-1:0] w_div_dn_sat;
  logic [CNT_W-1:0] w_ramp_dec;

  assign w_handshake = cmd_valid & r_ready;
  // The timer holds cycles remaining until the next pulse is presented.
  assign w_fire      = (r_timer <= DIV_W'(1));
  assign w_n         = r_steps_left - CNT_W'(1);

  assign w_div_up     = {1'b0, r_cur_div} + DEC_X;
  assign w_div_dn     = {1'b0, r_cur_div} - DEC_X;
  assign w_div_up_sat = (w_div_up > START_X) ? START_D : w_div_up[DIV_W-1:0];
  assign w_div_dn_sat = (w_div_dn[DIV_W] || (w_div_dn < MIN_X)) ? MIN_D : w_div_dn[DIV_W-1:0];
  assign w_ramp_dec   = (r_ramp == '0) ? '0 : r_ramp - CNT_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_div_next   = r_cur_div;
    w_ramp_next  = r_ramp;
    w_steps_next = r_steps_left;
    w_dir_next   = r_dir;
    w_pulse_next = 1'b0;
    w_done_next  = 1'b0;
    w_limit      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_dir_next   = cmd_dir;
          w_steps_next = cmd_steps;
          w_div_next   = START_D;
          w_ramp_next  = '0;
          // One cycle is consumed by the handshake itself.
          w_timer_next = START_D - DIV_W'(1);
          if (cmd_steps != '0) begin
            w_state_next = S_ACCEL;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      default: begin
        if (r_steps_left == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          if (w_fire) begin
            w_pulse_next = 1'b1;
            w_steps_next = w_n;
            if (w_n != '0) begin
              if (w_n <= r_ramp) begin
                w_state_next = S_DECEL;
                w_div_next   = w_div_up_sat;
                w_ramp_next  = w_ramp_dec;
              end else if (r_cur_div > MIN_D) begin
                w_state_next = S_ACCEL;
                w_div_next   = w_div_dn_sat;
                w_ramp_next  = r_ramp + CNT_W'(1);
              end else begin
                w_state_next = S_CRUISE;
              end
            end
            w_timer_next = w_div_next;
          end else begin
            w_timer_next = r_timer - DIV_W'(1);
          end
          // Abort trims the remaining count so the normal rules ramp down.
          w_limit = {1'b0, w_ramp_next} + (CNT_W+1)'(1);
          if (abort && ({1'b0, w_steps_next} > w_limit)) begin
            w_steps_next = w_limit[CNT_W-1:0];
          end
        end
      end
    endcase

    w_ready_next = (w_state_next == S_IDLE);
    w_busy_next  = (w_state_next != S_IDLE);
  end

  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_cur_div    <= START_D;
      r_ramp       <= '0;
      r_steps_left <= '0;
      r_dir        <= 1'b0;
      r_pulse      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_cur_div    <= w_div_next;
      r_ramp       <= w_ramp_next;
      r_steps_left <= w_steps_next;
      r_dir        <= w_dir_next;
      r_pulse      <= w_pulse_next;
      r_done       <= w_done_next;
      r_busy       <= w_busy_next;
      r_ready      <= w_ready_next;
    end
  end

  assign cmd_ready  = r_ready;
  assign step_pulse = r_pulse;
  assign dir        = r_dir;
  assign busy       = r_busy;
  assign done       = r_done;
  assign steps_left = r_steps_left;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: directed move table, reset/abort corner sequences,
// and random moves checked against a per-pulse profile model.
module tb_stepper_move_ctrl;
  localparam int CNT_W = 16;
  localparam int DIV_W = 20;
  localparam int SD    = 10;
  localparam int MD    = 4;
  localparam int AD    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_dir = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic             cmd_ready;
  logic             step_pulse;
  logic             dir;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stepper_move_ctrl #(
    .CNT_W(CNT_W), .DIV_W(DIV_W), .START_DIV(SD), .MIN_DIV(MD), .ACCEL_DEC(AD)
  ) dut (
    .CLK50MHZ(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .step_pulse(step_pulse),
    .dir(dir), .busy(busy), .done(done), .steps_left(steps_left)
  );

  typedef struct {
    int steps;
    bit d;
    int abort_k;
    int abort_off;
    bit hold;
    int exp_pulses;
    int exp_done;
  } vec_t;
  vec_t vecs[8];

  // Profile model: pulse times relative to the handshake cycle and steps_left after each.
  int m_t[$];
  int m_left[$];
  int m_done;
  int mv_pulses;
  int mv_done_at;

  function automatic void build_model(input int steps, input int abort_k);
    int left, ramp, dv, t, k;
    m_t.delete();
    m_left.delete();
    left = steps; ramp = 0; dv = SD; t = 0; k = 0;
    while (left > 0) begin
      t += dv;
      k++;
      left--;
      m_t.push_back(t);
      m_left.push_back(left);
      if (left == 0) break;
      if (left <= ramp) begin
        dv   = (dv + AD > SD) ? SD : dv + AD;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end else if (dv > MD) begin
        dv = (dv - AD < MD) ? MD : dv - AD;
        ramp++;
      end
      if (abort_k != 0 && k >= abort_k && left > ramp + 1) left = ramp + 1;
    end
    m_done = t + 1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_move(input string tag, input int steps, input bit d,
                          input int abort_k, input int abort_off, input bit hold);
    bit busy_bad, ready_bad, dir_bad, post_bad;
    int abort_at, limit;
    busy_bad = 0; ready_bad = 0; dir_bad = 0; post_bad = 0; abort_at = -1;
    build_model(steps, abort_k);
    limit = m_done + 20;
    @(negedge clk);
    chk({tag, " ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(steps);
    cmd_dir   = d;
    @(posedge clk);
    mv_pulses = 0;
    mv_done_at = -1;
    for (int t = 1; t <= limit && mv_done_at < 0; t++) begin
      @(negedge clk);
      if (!hold || steps == 0) cmd_valid = 1'b0;
      else begin
        cmd_steps = CNT_W'($urandom_range(1, 50));
        cmd_dir   = ~d;
      end
      if (t == abort_at) abort = 1'b1;
      if (step_pulse) begin
        if (mv_pulses < m_t.size()) begin
          chk($sformatf("%s pulse%0d_time", tag, mv_pulses + 1), t, m_t[mv_pulses]);
          chk($sformatf("%s pulse%0d_steps_left", tag, mv_pulses + 1), steps_left, m_left[mv_pulses]);
        end
        mv_pulses++;
        if (abort_k != 0 && mv_pulses == abort_k) begin
          if (abort_off == 0) abort = 1'b1;
          else abort_at = t + abort_off;
        end
      end
      if (dir !== d) dir_bad = 1;
      if (done) begin
        mv_done_at = t;
        cmd_valid = 1'b0;
        abort = 1'b0;
        chk({tag, " done_state"}, {busy, cmd_ready, steps_left}, {1'b0, 1'b1, 16'h0000});
      end else begin
        if (busy !== (steps > 0)) busy_bad = 1;
        if (cmd_ready !== (steps == 0)) ready_bad = 1;
      end
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    chk({tag, " pulse_count"}, mv_pulses, m_t.size());
    chk({tag, " done_time"}, mv_done_at, m_done);
    chk({tag, " busy_during"}, busy_bad, 0);
    chk({tag, " ready_during"}, ready_bad, 0);
    chk({tag, " dir_held"}, dir_bad, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (step_pulse || done || busy || dir !== d || steps_left != '0) post_bad = 1;
    end
    chk({tag, " post_idle"}, post_bad, 0);
    $display("move %s steps=%0d dir=%0d abort_k=%0d pulses=%0d done_at=%0d", tag, steps, d,
             abort_k, mv_pulses, mv_done_at);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int n, s, ak, ao;
    bit rd, rh;

    vecs[0] = '{10,  1, 0,  0, 0, 10, 65};
    vecs[1] = '{3,   0, 0,  0, 0, 3,  29};
    vecs[2] = '{0,   1, 0,  0, 0, 0,  1};
    vecs[3] = '{1,   0, 0,  0, 0, 1,  11};
    vecs[4] = '{2,   1, 0,  0, 0, 2,  19};
    vecs[5] = '{100, 1, 40, 0, 0, 44, 201};
    vecs[6] = '{20,  0, 1,  2, 1, 3,  29};
    vecs[7] = '{100, 0, 6,  2, 0, 10, 65};

    // Reset, then idle
    @(posedge clk);
    @(negedge clk);
    chk("t1 rst_flags", {step_pulse, busy, done, dir, cmd_ready}, 0);
    chk("t1 rst_steps_left", steps_left, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t1 ready_after_release", cmd_ready, 1);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (step_pulse || busy || done || !cmd_ready) bad = 1;
    end
    chk("t1 idle_quiet", bad, 0);

    // Abort while idle has no effect
    abort = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (step_pulse || busy || done || !cmd_ready || steps_left != '0) bad = 1;
    end
    abort = 1'b0;
    chk("idle_abort_ignored", bad, 0);

    foreach (vecs[i]) begin
      run_move($sformatf("vec%0d", i), vecs[i].steps, vecs[i].d, vecs[i].abort_k,
               vecs[i].abort_off, vecs[i].hold);
      chk($sformatf("vec%0d table_pulses", i), mv_pulses, vecs[i].exp_pulses);
      chk($sformatf("vec%0d table_done", i), mv_done_at, vecs[i].exp_done);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a move
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(10);
    cmd_dir = 1'b1;
    @(posedge clk);
    n = 0;
    for (int t = 1; t <= 200 && n < 5; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (step_pulse) n++;
    end
    chk("t6 reached_pulse5", n, 5);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6 rst_flags", {step_pulse, busy, done, dir, cmd_ready}, 0);
      chk("t6 rst_steps_left", steps_left, 0);
    end
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (step_pulse || done || busy) bad = 1;
    end
    chk("t6 quiet_after_reset", bad, 0);
    run_move("t6 new_cmd", 4, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      s  = $urandom_range(0, 30);
      rd = 1'($urandom_range(0, 1));
      ak = 0;
      if (s > 0 && $urandom_range(0, 1) == 1) ak = $urandom_range(1, s);
      ao = 2 * $urandom_range(0, 1);
      rh = 1'($urandom_range(0, 1));
      run_move($sformatf("rnd%0d", i), s, rd, ak, ao, rh);
      repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
